send: RTL

SEND -- requirements
Module: send

---
 rtl/send_pkg.sv | 22 ++
 rtl/send_flop.sv | 31 +++
 rtl/send.sv | 70 +++++++
 3 files changed

// File: rtl/send_pkg.sv
// Frame constants and stage encoding shared by the serial transmitter and receiver.
package send_pkg;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   BIT_SIZE  = 8;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOADED = 4'd1,
        START  = 4'd2,
        D0     = 4'd3,
        D1     = 4'd4,
        D2     = 4'd5,
        D3     = 4'd6,
        D4     = 4'd7,
        D5     = 4'd8,
        D6     = 4'd9,
        D7     = 4'd10,
        PARITY = 4'd11,
        STOP   = 4'd12
    } stage_t;
endpackage

// File: rtl/send_flop.sv
// Register primitives: synchronous reset has priority over the load enable.
module flopr_en #(
    parameter int             W   = 1,
    parameter logic [W-1:0]   RST = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)     q <= RST;
        else if (en) q <= d;
    end
endmodule

module bflopr_en #(
    parameter logic RST = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk) begin
        if (rst)     q <= RST;
        else if (en) q <= d;
    end
endmodule

// File: rtl/send.sv
// Serial frame transmitter: start, LSB-first data, odd parity, stop; advances one bit per i_en strobe.
module send #(
    parameter int BIT_SIZE = send_pkg::BIT_SIZE
) (
    input  logic                clk,
    input  logic                i_sclr,
    input  logic                i_en,
    input  logic                i_valid,
    input  logic [BIT_SIZE-1:0] i_data,
    output logic                o_ready,
    output logic                o_dat,
    output logic                o_done
);
    import send_pkg::*;

    localparam logic [3:0] D_LAST = 4'(int'(D0) + BIT_SIZE - 1);

    function automatic stage_t next_stage(input stage_t s);
        case (s)
            IDLE:    return IDLE;
            LOADED:  return START;
            PARITY:  return STOP;
            STOP:    return IDLE;
            default: return (s == stage_t'(D_LAST)) ? PARITY : stage_t'(s + 4'd1);
        endcase
    endfunction

    logic [3:0]          stage_q;
    stage_t              stage, stage_d;
    logic [BIT_SIZE-1:0] shift_q, shift_d;
    logic                par_q, par_d, dat_d, done_d;
    logic                accept, step, shifting;
    logic                stage_en, shift_en;

    assign stage   = stage_t'(stage_q);
    assign o_ready = (stage == IDLE);
    assign accept  = i_valid & o_ready;
    assign step    = i_en & ~o_ready;
    // Each data bit leaves the shifter on the strobe that enters its own stage.
    assign shifting = (stage >= START) && (4'(stage) < D_LAST);

    always_comb begin
        stage_en = accept | step;
        stage_d  = accept ? LOADED : next_stage(stage);
        shift_en = accept | (step & shifting);
        shift_d  = accept ? i_data : (shift_q >> 1);
        par_d    = accept ? 1'b1 : (par_q ^ shift_q[0]);
        done_d   = i_en & (stage == STOP);
        dat_d    = STOP_BIT;
        if (stage == LOADED)                     dat_d = START_BIT;
        else if (shifting)                       dat_d = shift_q[0];
        else if (stage == stage_t'(D_LAST))      dat_d = par_q;
    end

    flopr_en #(.W(4), .RST(4'(IDLE))) u_stage (
        .clk(clk), .rst(i_sclr), .en(stage_en), .d(4'(stage_d)), .q(stage_q)
    );
    flopr_en #(.W(BIT_SIZE), .RST('0)) u_shift (
        .clk(clk), .rst(i_sclr), .en(shift_en), .d(shift_d), .q(shift_q)
    );
    bflopr_en #(.RST(1'b1)) u_par (
        .clk(clk), .rst(i_sclr), .en(shift_en), .d(par_d), .q(par_q)
    );
    bflopr_en #(.RST(STOP_BIT)) u_dat (
        .clk(clk), .rst(i_sclr), .en(step), .d(dat_d), .q(o_dat)
    );
    bflopr_en #(.RST(1'b0)) u_done (
        .clk(clk), .rst(i_sclr), .en(1'b1), .d(done_d), .q(o_done)
    );
endmodule
